pixel_mem_reader: RTL and testbench

Frame scanner that reads the pixel memory written by the processor's `memPixWrite` path and streams its contents out as a valid/ready pixel stream. It is the read-side counterpart of the pipeline's pixel-memory store path and sits between the pixel memory's read port and the display/dump sink. On each `start`, it walks one full frame of `WIDTH*HEIGHT` pixels in raster order, tags line and frame boundaries, and pulses `done`.

---
 rtl/pixel_mem_reader.sv | 144 ++++++++++++++
 tb/tb_pixel_mem_reader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_mem_reader.sv
// rtl/pixel_mem_reader.sv - raster frame scanner from pixel memory to a valid/ready pixel stream
// Define PIXREAD_BYTE_UNPACK_EN to unpack four little-endian 8-bit pixels from each 32-bit word.
module pixel_mem_reader #(
  parameter int WIDTH     = 256,
  parameter int HEIGHT    = 256,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int PIX_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              busy,
  output logic              done
);
  localparam int NPIX = WIDTH * HEIGHT;
`ifdef PIXREAD_BYTE_UNPACK_EN
  localparam int NW = NPIX / 4;
`else
  localparam int NW = NPIX;
`endif
  localparam int WW = $clog2(NW + 1);
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t            state;
  logic [31:0]       wbuf [2];
  logic              head;
  logic              tail;
  logic [1:0]        count;
  logic              inflight;
  logic [WW-1:0]     rd_idx;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [2:0]        occ;
  logic              xfer;
  logic              pop;
  logic              last_pix;
  logic [31:0]       head_word;
  logic [PIX_W-1:0]  head_pix;

  assign head_word = wbuf[head];
  assign pix_valid = (count != 2'd0);
  assign xfer      = pix_valid & pix_ready;

`ifdef PIXREAD_BYTE_UNPACK_EN
  logic [1:0] sub;
  assign head_pix = PIX_W'(head_word[{sub, 3'b000} +: 8]);
  assign pop      = xfer & (sub == 2'd3);
`else
  logic unused_hi;
  assign head_pix  = head_word[PIX_W-1:0];
  assign unused_hi = ^head_word;
  assign pop       = xfer;
`endif

  // The read in flight counts against the two slots, so a returning word always has room.
  assign occ       = 3'(count) + 3'(inflight) - 3'(pop);
  assign mem_rd    = (state == SCAN) && (occ < 3'd2);
  assign next_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_idx);
  assign mem_addr  = mem_rd ? next_addr : last_addr;

  assign last_pix  = (x == XW'(WIDTH - 1)) && (y == YW'(HEIGHT - 1));
  assign pix_data  = pix_valid ? head_pix : '0;
  assign pix_sof   = pix_valid && (x == '0) && (y == '0);
  assign pix_eol   = pix_valid && (x == XW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      head      <= 1'b0;
      tail      <= 1'b0;
      count     <= 2'd0;
      inflight  <= 1'b0;
      rd_idx    <= '0;
      last_addr <= ADDR_W'(BASE_ADDR);
      x         <= '0;
      y         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PIXREAD_BYTE_UNPACK_EN
      sub       <= 2'd0;
`endif
    end else begin
      inflight <= mem_rd;
      count    <= count + 2'(inflight) - 2'(pop);
      if (inflight) begin
        wbuf[tail] <= mem_rdata;
        tail       <= ~tail;
      end
      if (pop) head <= ~head;
      if (mem_rd) begin
        last_addr <= next_addr;
        rd_idx    <= rd_idx + WW'(1);
      end
      if (xfer) begin
`ifdef PIXREAD_BYTE_UNPACK_EN
        sub <= sub + 2'd1;
`endif
        if (x == XW'(WIDTH - 1)) begin
          x <= '0;
          y <= (y == YW'(HEIGHT - 1)) ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SCAN;
            busy   <= 1'b1;
            rd_idx <= '0;
          end
        end
        SCAN: begin
          if (mem_rd && (rd_idx == WW'(NW - 1))) state <= DRAIN;
        end
        DRAIN: begin
          // The final transfer also empties the buffer, since every word has been consumed.
          if (xfer && last_pix) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_mem_reader.sv
// tb/tb_pixel_mem_reader.sv - self-checking bench for pixel_mem_reader against a frame-level model
`timescale 1ns/1ps
module tb_pixel_mem_reader;
  localparam int W = 4;
  localparam int H = 2;
  localparam int NPIX = W * H;
`ifdef PIXREAD_BYTE_UNPACK_EN
  localparam int PPW = 4;
`else
  localparam int PPW = 1;
`endif
  localparam int NW_A   = NPIX / PPW;
  localparam int BASE_A = 'h20;
  localparam int NPIX_B = 4;
  localparam int NW_B   = NPIX_B / PPW;
  localparam int BASE_B = 14;

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, pix_ready, b_start, b_pix_ready;
  logic        mem_rd, pix_valid, pix_sof, pix_eol, busy, done;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [7:0]  pix_data;
  logic        b_mem_rd, b_pix_valid, b_pix_sof, b_pix_eol, b_busy, b_done;
  logic [3:0]  b_mem_addr;
  logic [31:0] b_mem_rdata;
  logic [7:0]  b_pix_data;

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:15];

  pixel_mem_reader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(16), .BASE_ADDR(BASE_A), .PIX_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .busy(busy), .done(done)
  );

  pixel_mem_reader #(.WIDTH(4), .HEIGHT(1), .ADDR_W(4), .BASE_ADDR(BASE_B), .PIX_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .mem_rd(b_mem_rd), .mem_addr(b_mem_addr),
    .mem_rdata(b_mem_rdata), .pix_data(b_pix_data), .pix_valid(b_pix_valid), .pix_ready(b_pix_ready),
    .pix_sof(b_pix_sof), .pix_eol(b_pix_eol), .busy(b_busy), .done(b_done)
  );

  // Memory returns data one cycle after the strobe and junk otherwise; it ignores reset.
  always @(posedge clk) mem_rdata   <= (mem_rd === 1'b1) ? mem_a[mem_addr[7:0]] : 32'hDEAD_BEEF;
  always @(posedge clk) b_mem_rdata <= (b_mem_rd === 1'b1) ? mem_b[b_mem_addr] : 32'hDEAD_BEEF;

  int   n_assert = 0;
  int   n_fail = 0;
  int   fc, reads, xfers, done_cnt, first_valid_fc, last_xfer_fc, b_done_cnt;
  bit   model_on, started, prev_stall;
  pix_t prev;
  pix_t exp_q[$];
  logic [3:0] b_addr_q[$];
  logic [7:0] b_pix_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_a(input int i);
    logic [31:0] w;
    w = mem_a[(BASE_A + i / PPW) % 256];
    return w[8 * (i % PPW) +: 8];
  endfunction

  function automatic logic [7:0] model_b(input int i);
    logic [31:0] w;
    w = mem_b[(BASE_B + i / PPW) % 16];
    return w[8 * (i % PPW) +: 8];
  endfunction

  task automatic init_frame();
    pix_t p;
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      p.d = model_a(i);
      p.s = (i == 0);
      p.e = ((i % W) == W - 1);
      exp_q.push_back(p);
    end
    reads = 0; xfers = 0; done_cnt = 0;
    first_valid_fc = -1; last_xfer_fc = -100;
    model_on = 1'b1; started = 1'b1; prev_stall = 1'b0;
    fc = -1;
  endtask

  task automatic observe_a();
    int   occ;
    logic busy_exp, done_exp;
    if (!model_on) return;
    occ = reads - xfers / PPW;
    check("occupancy_le2", occ <= 2, 1'b1);
    busy_exp = started && (fc >= 1) && (xfers < NPIX);
    done_exp = started && (xfers == NPIX) && (fc == last_xfer_fc + 1);
    check("busy", busy, busy_exp);
    check("done", done, done_exp);
    if (done === 1'b1) done_cnt++;
    if (mem_rd === 1'b1) begin
      check("mem_addr", mem_addr, 32'((BASE_A + reads) % 65536));
      reads++;
    end
    if (prev_stall) begin
      check("stall_valid", pix_valid, 1'b1);
      check("stall_data", pix_data, prev.d);
      check("stall_sof", pix_sof, prev.s);
      check("stall_eol", pix_eol, prev.e);
    end
    prev_stall = 1'b0;
    if (pix_valid === 1'b1) begin
      if (first_valid_fc < 0) first_valid_fc = fc;
      if (exp_q.size() == 0) begin
        check("extra_pixel", xfers < NPIX, 1'b1);
      end else begin
        check("pix_data", pix_data, exp_q[0].d);
        check("pix_sof", pix_sof, exp_q[0].s);
        check("pix_eol", pix_eol, exp_q[0].e);
      end
      if (pix_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        xfers++;
        last_xfer_fc = fc;
      end else begin
        prev_stall = 1'b1;
        prev.d = pix_data; prev.s = pix_sof; prev.e = pix_eol;
      end
    end else begin
      check("idle_data_zero", pix_data, 8'h00);
    end
  endtask

  task automatic observe_b();
    if (b_mem_rd === 1'b1) b_addr_q.push_back(b_mem_addr);
    if ((b_pix_valid === 1'b1) && b_pix_ready) b_pix_q.push_back(b_pix_data);
    if (b_done === 1'b1) b_done_cnt++;
  endtask

  task automatic run_cycle(input logic rst, input logic st, input logic rdy, input logic bst);
    @(posedge clk);
    #1;
    fc++;
    reset = rst; start = st; pix_ready = rdy; b_start = bst;
    #1;
    observe_a();
    observe_b();
  endtask

  task automatic run_frame(input int pct, input bit ign, input int stop_after);
    logic st, rdy;
    init_frame();
    for (int c = 0; c < 400; c++) begin
      st  = (c == 0) || (ign && (c == 2 || c == 5 || c == 11));
      rdy = ($urandom_range(0, 99) < pct);
      run_cycle(1'b1, st, rdy, 1'b0);
      if (xfers >= stop_after && (stop_after < NPIX || fc > last_xfer_fc + 12)) break;
    end
  endtask

  task automatic frame_end_checks();
    check("frame_xfers", xfers, NPIX);
    check("frame_reads", reads, NW_A);
    check("frame_queue_empty", exp_q.size(), 0);
    check("frame_done_once", done_cnt, 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_addr", mem_addr, BASE_A);
    check("rst_pix_valid", pix_valid, 1'b0);
    check("rst_pix_data", pix_data, 8'h00);
    check("rst_pix_sof", pix_sof, 1'b0);
    check("rst_pix_eol", pix_eol, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_b_mem_addr", b_mem_addr, BASE_B);
    check("rst_b_pix_valid", b_pix_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; pix_ready = 1'b0; b_start = 1'b0; b_pix_ready = 1'b1;
    model_on = 1'b0; started = 1'b0; fc = 0; b_done_cnt = 0;
    for (int i = 0; i < 256; i++) mem_a[i] = $urandom;
    for (int i = 0; i < 16; i++) mem_b[i] = $urandom;
`ifdef PIXREAD_BYTE_UNPACK_EN
    mem_a[BASE_A]     = 32'h03020100;
    mem_a[BASE_A + 1] = 32'h07060504;
`else
    for (int i = 0; i < NPIX; i++) mem_a[BASE_A + i] = 32'h10 + i;
`endif

    repeat (3) run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_reset_outputs();
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Full-rate frame with start re-pulsed while busy and in DONE.
    run_frame(100, 1'b1, NPIX);
    check("first_valid_cycle", first_valid_fc, 3);
    check("last_xfer_cycle", last_xfer_fc, NPIX + 2);
    frame_end_checks();

    run_frame(30, 1'b0, NPIX);
    frame_end_checks();

    // Reset after three transfers, then a clean restart.
    run_frame(50, 1'b0, 3);
    model_on = 1'b0;
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_reset_outputs();
    repeat (3) begin
      run_cycle(1'b1, 1'b0, 1'b1, 1'b0);
      check("no_stale_valid", pix_valid, 1'b0);
    end
    run_frame(100, 1'b0, NPIX);
    frame_end_checks();

    for (int i = 0; i < NW_A; i++) mem_a[BASE_A + i] = $urandom;
    run_frame(60, 1'b0, NPIX);
    frame_end_checks();

    // Address wrap on the narrow-address instance.
    model_on = 1'b0;
    b_addr_q.delete(); b_pix_q.delete(); b_done_cnt = 0;
    run_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (20) run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("wrap_reads", b_addr_q.size(), NW_B);
    for (int j = 0; j < NW_B; j++)
      if (j < b_addr_q.size()) check("wrap_addr", b_addr_q[j], (BASE_B + j) % 16);
    check("wrap_pixels", b_pix_q.size(), NPIX_B);
    for (int i = 0; i < NPIX_B; i++)
      if (i < b_pix_q.size()) check("wrap_pix", b_pix_q[i], model_b(i));
    check("wrap_done", b_done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
